// File: rtl/sm_regdump_pkg.sv
// Shared definitions for the register-dump UART transmitter: FSM encoding,
// ASCII constants, nibble-to-hex conversion and line lengths.
package sm_regdump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_CHAR = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

  localparam int NUM_REGS        = 32;
  localparam int LINE_LEN_PLAIN  = 10;  // 8 hex digits + CR + LF
  localparam int LINE_LEN_PREFIX = 13;  // "NN:" + 8 hex digits + CR + LF

  // Uppercase ASCII hex digit for a 4-bit value.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return ASC_0 + {4'b0000, n};
    else           return ASC_A + {4'b0000, n} - 8'd10;
  endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface. ready is high when
// idle and in the final stop-bit cycle, so bytes can be chained with no gap.
module sm_uart_tx
  import sm_regdump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic        active_q, active_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  assign ready = !active_q || (bit_q == 4'd9 && baud_q == 16'd0);
  assign tx    = tx_q;

  // Frame sequencing: down-count each bit, shift data out LSB first.
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (valid && ready) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      baud_d   = BAUD_LAST;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q != 16'd0) begin
        baud_d = baud_q - 16'd1;
      end else if (bit_q == 4'd9) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_d  = bit_q + 4'd1;
        baud_d = BAUD_LAST;
        if (bit_q == 4'd8) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
    end
  end

  // State registers; tx resets high asynchronously so a reset cuts a frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= 16'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/sm_regdump_uart.sv
// Register-file dump transmitter: walks regAddr 0..31 on the CPU debug port,
// snapshots each regData value and sends it as an ASCII hex line over UART.
// Optional build macro SM_REGDUMP_ADDR_PREFIX_EN prefixes each line with "NN:".
//
// state | meaning
// IDLE  | waiting for start, tx idle
// ADDR  | regAddr driven, settling; snapshot taken on the last settle cycle
// LOAD  | character index cleared
// CHAR  | handing line characters to the UART one by one
// NEXT  | advance to next register, or finish after the last one drains
module sm_regdump_uart
  import sm_regdump_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef SM_REGDUMP_ADDR_PREFIX_EN
  localparam int LINE_LEN = LINE_LEN_PREFIX;
`else
  localparam int LINE_LEN = LINE_LEN_PLAIN;
`endif
  localparam logic [3:0] LAST_CHAR   = 4'(LINE_LEN - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [4:0] LAST_REG    = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [3:0]  settle_q, settle_d;
  logic [31:0] snap_q, snap_d;
  logic [3:0]  cidx_q, cidx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] snap_sh;

  assign regAddr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Select the character at cidx_q: hex digits come MSB nibble first.
  always_comb begin
    tx_data = ASC_CR;
    snap_sh = 32'd0;
`ifdef SM_REGDUMP_ADDR_PREFIX_EN
    snap_sh = snap_q << {cidx_q - 4'd3, 2'b00};
    case (cidx_q)
      4'd0:    tx_data = nib2ascii({3'b000, addr_q[4]});
      4'd1:    tx_data = nib2ascii(addr_q[3:0]);
      4'd2:    tx_data = ASC_COLON;
      4'd11:   tx_data = ASC_CR;
      4'd12:   tx_data = ASC_LF;
      default: tx_data = nib2ascii(snap_sh[31:28]);
    endcase
`else
    snap_sh = snap_q << {cidx_q, 2'b00};
    case (cidx_q)
      4'd8:    tx_data = ASC_CR;
      4'd9:    tx_data = ASC_LF;
      default: tx_data = nib2ascii(snap_sh[31:28]);
    endcase
`endif
  end

  // Dump sequencer: next state and register updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    settle_d = settle_q;
    snap_d   = snap_q;
    cidx_d   = cidx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ADDR;
          addr_d   = 5'd0;
          busy_d   = 1'b1;
          settle_d = SETTLE_LAST;
        end
      end
      ST_ADDR: begin
        if (settle_q == 4'd0) begin
          snap_d  = regData;
          state_d = ST_LOAD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_LOAD: begin
        cidx_d  = 4'd0;
        state_d = ST_CHAR;
      end
      ST_CHAR: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (cidx_q == LAST_CHAR) state_d = ST_NEXT;
          else                     cidx_d  = cidx_q + 4'd1;
        end
      end
      ST_NEXT: begin
        if (addr_q == LAST_REG) begin
          // tx_ready here means the final LF is in its last stop-bit cycle.
          if (tx_ready) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          addr_d   = addr_q + 5'd1;
          settle_d = SETTLE_LAST;
          state_d  = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 5'd0;
      settle_q <= 4'd0;
      snap_q   <= 32'd0;
      cidx_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      snap_q   <= snap_d;
      cidx_q   <= cidx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sm_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: doc/sm_regdump_uart.md
# sm_regdump_uart

Register-file dump transmitter for schoolMIPS boards. It acts as the initiator on the CPU debug port (`regAddr`/`regData`): it walks all 32 architectural registers, snapshots each value, and sends it as ASCII hex lines over a UART TX pin. It sits beside the CPU core in the board top, in the fast `clkIn` domain, and replaces switch-driven register inspection.

## Interface
- `BAUD_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `SETTLE`, default 2: cycles `regAddr` is held before `regData` is sampled; legal range 1..15.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level input; a dump begins on any cycle where `start`=1 and the block is idle.
- `regAddr` out 5: register index driven to the CPU debug port.
- `regData` in 32: register value returned by the CPU debug port.
- `tx` out 1: UART serial output, 8N1, idle high.
- `busy` out 1: high from the cycle after `start` is accepted until the final stop bit completes.
- `done` out 1: one-cycle pulse on the cycle `busy` falls.

## Operation
- FSM states: IDLE, ADDR, LOAD, CHAR, NEXT.
- IDLE: `tx`=1. `start`=1 -> ADDR, `regAddr`<=0, `busy`<=1.
- ADDR: hold `regAddr` for SETTLE cycles, then capture `regData` into a 32-bit snapshot -> LOAD.
- LOAD: reset the character index to 0 -> CHAR.
- CHAR: emit one line per register: 8 uppercase hex digits, MSB nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then CR (0x0D) and LF (0x0A). That is 10 characters per line.
- CHAR hands each byte to the TX sub-block with a valid/ready handshake. After the LF is accepted -> NEXT.
- NEXT: if `regAddr`=31, wait for the TX sub-block to go idle, pulse `done`, clear `busy`, and go to IDLE. Otherwise increment `regAddr` -> ADDR.
- `regAddr` wraps from 31 only by returning to IDLE. It keeps its last value (31) in IDLE until the next dump sets it to 0.
- `start` while `busy` is ignored. It is not queued.
- `start` held high continuously restarts a dump on the cycle after `done`.
- The snapshot is immune to `regData` changing during transmission.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `regAddr`=0, FSM=IDLE, baud counter=0.
- Assertion of `rst` mid-frame forces `tx` high immediately (asynchronously). This may truncate a character.
- UART frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles, so one frame is 10*BAUD_DIV cycles.
- Characters within a line are sent back-to-back with no idle gap. The next byte is accepted in the stop bit's last cycle.
- Between lines, the gap is at most SETTLE+3 cycles of idle-high.
- `tx` falls (start bit of the first character) at most SETTLE+4 cycles after `start` is sampled.
- Total dump time ≈ 32*(100*BAUD_DIV + SETTLE + 3) cycles.
- `tx` is driven from a flop; it has no combinational path from any input.

## Configuration
- `SM_REGDUMP_ADDR_PREFIX_EN` defined: each line is prefixed with the register index as 2 uppercase hex digits and ':' (e.g. "1F:"). Lines are then 13 characters.
- Macro undefined: lines are 10 characters with no prefix. Prefix logic and its counter width are removed.

## Structure
- Shared package/header `sm_regdump_pkg`: FSM state encodings, ASCII constants (CR, LF, ':', '0', 'A'), the nibble-to-ASCII function, and line-length constants for both configurations.
- Sub-module `sm_uart_tx`, parameter BAUD_DIV. Ports: `clk`, `rst`, `data[7:0]`, `valid`, `ready`, `tx`.
  - `ready` is high in idle and in the last stop-bit cycle.
  - A byte is accepted when `valid`&&`ready` are both high.

## Test plan
- Basic dump: BAUD_DIV=4, SETTLE=2, register model returns 0x1000_0000+index, pulse `start`. UART monitor decodes 32 lines "1000000X…" in order. Line 0 is "10000000\r\n" and line 31 is "1000001F\r\n". `done` pulses once and `busy` is low afterwards.
- Hex coverage: register 5=0xDEADBEEF, register 6=0x0123A5F9. Lines read "DEADBEEF" and "0123A5F9". No lowercase characters appear.
- Snapshot stability: change `regData` every cycle after the LOAD state. The transmitted line equals the value present at the sample cycle.
- Start while busy: pulse `start` mid-dump. Exactly 32 lines are sent and only one `done` occurs.
- Reset mid-character: assert `rst` during bit 3 of a character. `tx`=1 the same cycle, and `busy`=0 and `regAddr`=0 after reset. A new `start` produces a clean full dump.
- With `SM_REGDUMP_ADDR_PREFIX_EN` defined: line 10 reads "0A:1000000A\r\n". Bit timing is checked as exactly 4 cycles per bit across the whole dump.
